// File: rtl/ps2_scan_fifo_rx_if.sv
// Key-event stream: FIFO head plus valid/ready handshake.
interface ps2_scan_fifo_rx_if;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output evt_code,
    output evt_break,
    output evt_ext,
    output evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_code,
    input  evt_break,
    input  evt_ext,
    input  evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scan_fifo_rx.sv
// PS/2 keyboard receiver: line conditioning, frame FSM with timeout,
// E0/F0 prefix decode and a first-word-fall-through event FIFO.
module ps2_scan_fifo_rx #(
  parameter int unsigned CLK_FILTER     = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          PARITY_CHECK   = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_dat,
  ps2_scan_fifo_rx_if.master          evt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] DepthC = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodePause = 8'hE1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_meta, clk_sync, dat_meta, dat_sync;
  logic          filt, filt_flip, fall;
  logic [3:0]    filt_cnt;
  state_e        state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          tmo_hit, frame_good, frame_bad;
  logic          byte_vld_q, frame_err_q;
  logic [7:0]    byte_q;
  logic          ext_q, brk_q, is_prefix, push_req, push_ok, pop, overflow_q;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [9:0]    head, hold_q;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_sync <= clk_meta;
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

  assign filt_flip = (clk_sync != filt) && (filt_cnt == 4'(CLK_FILTER - 1));

  // Glitch filter on the clock line and one-cycle falling-edge strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt     <= 1'b1;
      filt_cnt <= 4'd0;
      fall     <= 1'b0;
    end else begin
      fall <= filt & filt_flip;
      if (clk_sync != filt) begin
        if (filt_flip) begin
          filt     <= ~filt;
          filt_cnt <= 4'd0;
        end else begin
          filt_cnt <= filt_cnt + 4'd1;
        end
      end else begin
        filt_cnt <= 4'd0;
      end
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Frame FSM next state; a timeout overrides the bit strobe.
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle:   if (!dat_sync) state_d = StData;
        StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Frame FSM outputs: frame verdict and timeout detection.
  always_comb begin
    tmo_hit    = !fall && (state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    frame_good = fall && (state_q == StStop) && dat_sync &&
                 (!PARITY_CHECK || ((^shift_q) ^ par_q));
    frame_bad  = (fall && (state_q == StStop) && !frame_good) || tmo_hit;
  end

  // Frame datapath: shifter, bit counter, parity, timeout counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      tmo_q <= (fall || state_q == StIdle) ? '0 : tmo_q + 1'b1;
      if (fall) begin
        if (state_q == StIdle) bit_cnt_q <= 3'd0;
        if (state_q == StData) begin
          shift_q   <= {dat_sync, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        if (state_q == StParity) par_q <= dat_sync;
      end
      byte_vld_q  <= frame_good;
      if (frame_good) byte_q <= shift_q;
      frame_err_q <= frame_bad;
    end
  end

  assign is_prefix = (byte_q == CodeExt) || (byte_q == CodeBrk) || (byte_q == CodePause);
  assign push_req  = byte_vld_q && !is_prefix;
  assign pop       = (count_q != '0) && evt.evt_ready;
  assign push_ok   = push_req && ((count_q != DepthC) || pop);

  // Prefix flags: set by E0/F0, cleared by any delivered or dropped key and by errors.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_bad) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == CodeExt) begin
        ext_q <= 1'b1;
      end else if (byte_q == CodeBrk) begin
        brk_q <= 1'b1;
      end else if (byte_q != CodePause) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

  // Event FIFO storage and pointers; pointers wrap on the power-of-two depth.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr_q] <= {ext_q, brk_q, byte_q};
        wptr_q      <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      overflow_q <= push_req && !push_ok;
      if (count_q != '0) hold_q <= mem[rptr_q];
    end
  end

  // Head shows the oldest entry, or the last seen one while empty.
  assign head          = (count_q != '0) ? mem[rptr_q] : hold_q;
  assign evt.evt_code  = head[7:0];
  assign evt.evt_break = head[8];
  assign evt.evt_ext   = head[9];
  assign evt.evt_valid = (count_q != '0);
  assign fifo_count    = count_q;
  assign overflow      = overflow_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_fifo_rx.sv
// Self-checking bench: two receivers (parity checked / ignored) share the PS/2 lines.
module tb_ps2_scan_fifo_rx;
  localparam int HB    = 15;
  localparam int DEPTH = 8;
  localparam int TMO   = 2000;

  typedef logic [9:0] ev_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic [3:0] fifo_count_a, fifo_count_b;
  logic overflow_a, overflow_b, frame_err_a, frame_err_b;

  ps2_scan_fifo_rx_if evt_a ();
  ps2_scan_fifo_rx_if evt_b ();

  ps2_scan_fifo_rx #(
    .CLK_FILTER(4), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PARITY_CHECK(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .evt(evt_a), .fifo_count(fifo_count_a), .overflow(overflow_a), .frame_err(frame_err_a)
  );

  ps2_scan_fifo_rx #(
    .CLK_FILTER(4), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .PARITY_CHECK(1'b0)
  ) u_dut_np (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .evt(evt_b), .fifo_count(fifo_count_b), .overflow(overflow_b), .frame_err(frame_err_b)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Observed traffic.
  ev_t got_a[$], got_b[$];
  int  ovf_a = 0, ferr_a = 0, ferr_b = 0, valid_cyc_a = 0, max_cnt_a = 0;

  // Reference model state.
  ev_t exp_a[$], exp_b[$];
  bit  m_ext_a = 0, m_brk_a = 0, m_ext_b = 0, m_brk_b = 0;
  int  m_occ_a = 0, exp_ovf_a = 0, exp_ferr_a = 0, exp_ferr_b = 0;
  bit  hold_a = 0;

  // Consumer control for instance A.
  bit ready_cfg = 1'b1;
  bit rand_ready = 1'b0;

  always @(posedge clock) begin
    #1;
    evt_a.evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cfg;
  end

  // Passive collector: records accepted events and pulses.
  always @(negedge clock) begin
    if (reset_n) begin
      if (evt_a.evt_valid) valid_cyc_a++;
      if (evt_a.evt_valid && evt_a.evt_ready)
        got_a.push_back({evt_a.evt_ext, evt_a.evt_break, evt_a.evt_code});
      if (evt_b.evt_valid && evt_b.evt_ready)
        got_b.push_back({evt_b.evt_ext, evt_b.evt_break, evt_b.evt_code});
      if (overflow_a) ovf_a++;
      if (frame_err_a) ferr_a++;
      if (frame_err_b) ferr_b++;
      if (int'(fifo_count_a) > max_cnt_a) max_cnt_a = int'(fifo_count_a);
    end
  end

  initial begin
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: run exceeded cycle budget, required completion");
    $fatal(1);
  end

  // Keyboard-level model of one received frame.
  function automatic void model_frame(input bit pchk, input logic [7:0] code, input bit par_ok,
                                      input bit stop_ok, inout bit ext, inout bit brk,
                                      output bit err, output bit push, output ev_t ev);
    err  = !stop_ok || (pchk && !par_ok);
    push = 1'b0;
    ev   = {ext, brk, code};
    if (err) begin
      ext = 0;
      brk = 0;
    end else if (code == 8'hE0) ext = 1;
    else if (code == 8'hF0) brk = 1;
    else if (code != 8'hE1) begin
      push = 1'b1;
      ext  = 0;
      brk  = 0;
    end
  endfunction

  task automatic model_apply(input logic [7:0] code, input bit par_ok, input bit stop_ok);
    bit err, push;
    ev_t ev;
    model_frame(1'b1, code, par_ok, stop_ok, m_ext_a, m_brk_a, err, push, ev);
    if (err) exp_ferr_a++;
    if (push) begin
      if (!hold_a) exp_a.push_back(ev);
      else if (m_occ_a < DEPTH) begin
        exp_a.push_back(ev);
        m_occ_a++;
      end else exp_ovf_a++;
    end
    model_frame(1'b0, code, par_ok, stop_ok, m_ext_b, m_brk_b, err, push, ev);
    if (err) exp_ferr_b++;
    if (push) exp_b.push_back(ev);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      repeat (5) @(posedge clock);
      #1 ps2_clk = 1'b0;
      repeat (2) @(posedge clock);
      #1 ps2_clk = 1'b1;
      repeat (HB - 7) @(posedge clock);
      #1;
    end else begin
      repeat (HB) @(posedge clock);
      #1;
    end
    ps2_clk = 1'b0;
    repeat (HB) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                           input int glitch_bit);
    logic [10:0] f;
    f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i], i == glitch_bit);
    ps2_dat = 1'b1;
    repeat (4 * HB) @(posedge clock);
    #1;
    model_apply(code, !bad_par, !bad_stop);
  endtask

  task automatic clear_obs();
    got_a.delete();
    got_b.delete();
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic test_reset();
    ev_t h;
    h = {evt_a.evt_ext, evt_a.evt_break, evt_a.evt_code};
    checks++;
    if (evt_a.evt_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %0b exp 0", evt_a.evt_valid);
    end
    checks++;
    if (fifo_count_a !== 4'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", fifo_count_a);
    end
    checks++;
    if ({overflow_a, frame_err_a} !== 2'b00) begin
      errors++; $display("FAIL reset_pulses got %b exp 00", {overflow_a, frame_err_a});
    end
    checks++;
    if (h !== 10'h000) begin
      errors++; $display("FAIL reset_head got %0h exp 0", h);
    end
    reset_n = 1'b1;
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic test_single();
    int v0, f0, o0;
    clear_obs();
    v0 = valid_cyc_a; f0 = ferr_a; o0 = ovf_a;
    send_byte(8'h1C, 1'b0, 1'b0, -1);
    checks++;
    if (got_a.size() != 1) begin
      errors++; $display("FAIL single_count got %0d exp 1", got_a.size());
    end else begin
      checks++;
      if (got_a[0] !== 10'h01C) begin
        errors++; $display("FAIL single_event got %0h exp 01c", got_a[0]);
      end
    end
    checks++;
    if (valid_cyc_a - v0 != 1) begin
      errors++; $display("FAIL single_valid_cycles got %0d exp 1", valid_cyc_a - v0);
    end
    checks++;
    if ((ferr_a - f0) + (ovf_a - o0) != 0) begin
      errors++; $display("FAIL single_pulses got %0d exp 0", (ferr_a - f0) + (ovf_a - o0));
    end
  endtask

  task automatic test_prefix();
    logic [7:0] seq [5];
    ev_t want [2];
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h75};
    want = '{10'h11C, 10'h375};
    clear_obs();
    max_cnt_a = 0;
    foreach (seq[i]) send_byte(seq[i], 1'b0, 1'b0, -1);
    checks++;
    if (got_a.size() != 2) begin
      errors++; $display("FAIL prefix_count got %0d exp 2", got_a.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_a[i] !== want[i]) begin
          errors++; $display("FAIL prefix_event%0d got %0h exp %0h", i, got_a[i], want[i]);
        end
      end
    end
    checks++;
    if (max_cnt_a > 1) begin
      errors++; $display("FAIL prefix_max_count got %0d exp <=1", max_cnt_a);
    end
  endtask

  task automatic test_parity();
    int f0;
    clear_obs();
    f0 = ferr_a;
    send_byte(8'h1C, 1'b1, 1'b0, -1);
    checks++;
    if (ferr_a - f0 != 1 || got_a.size() != 0) begin
      errors++; $display("FAIL parity_reject got err %0d events %0d exp 1 0",
                         ferr_a - f0, got_a.size());
    end
    checks++;
    if (got_b.size() != 1 || (got_b.size() == 1 && got_b[0] !== 10'h01C)) begin
      errors++; $display("FAIL parity_ignored got %0d events exp one 01c", got_b.size());
    end
    clear_obs();
    send_byte(8'hE0, 1'b0, 1'b0, -1);
    send_byte(8'h1C, 1'b1, 1'b0, -1);
    send_byte(8'h6B, 1'b0, 1'b0, -1);
    checks++;
    if (got_a.size() != 1 || (got_a.size() == 1 && got_a[0] !== 10'h06B)) begin
      errors++; $display("FAIL parity_flag_clear got %0d events head %0h exp one 06b",
                         got_a.size(), got_a.size() > 0 ? got_a[0] : 10'h3FF);
    end
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++; $display("FAIL parity_b_count got %0d exp %0d", got_b.size(), exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++; $display("FAIL parity_b_event%0d got %0h exp %0h", i, got_b[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int fa0, fb0, o0, r;
    logic [7:0] code;
    clear_obs();
    fa0 = ferr_a; fb0 = ferr_b; o0 = ovf_a;
    exp_ferr_a = 0; exp_ferr_b = 0;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 99);
      if (r < 15) code = 8'hE0;
      else if (r < 30) code = 8'hF0;
      else if (r < 33) code = 8'hE1;
      else code = 8'($urandom_range(0, 255));
      send_byte(code, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, -1);
    end
    repeat (20) @(posedge clock);
    #1;
    rand_ready = 1'b0;
    checks++;
    if (got_a.size() != exp_a.size()) begin
      errors++; $display("FAIL random_a_count got %0d exp %0d", got_a.size(), exp_a.size());
    end else begin
      foreach (exp_a[i]) begin
        checks++;
        if (got_a[i] !== exp_a[i]) begin
          errors++; $display("FAIL random_a_event%0d got %0h exp %0h", i, got_a[i], exp_a[i]);
        end
      end
    end
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++; $display("FAIL random_b_count got %0d exp %0d", got_b.size(), exp_b.size());
    end else begin
      foreach (exp_b[i]) begin
        checks++;
        if (got_b[i] !== exp_b[i]) begin
          errors++; $display("FAIL random_b_event%0d got %0h exp %0h", i, got_b[i], exp_b[i]);
        end
      end
    end
    checks++;
    if (ferr_a - fa0 != exp_ferr_a || ferr_b - fb0 != exp_ferr_b || ovf_a != o0) begin
      errors++; $display("FAIL random_pulses got a %0d b %0d ovf %0d exp %0d %0d 0",
                         ferr_a - fa0, ferr_b - fb0, ovf_a - o0, exp_ferr_a, exp_ferr_b);
    end
  endtask

  task automatic test_overflow();
    int o0;
    for (int round = 0; round < 3; round++) begin
      clear_obs();
      hold_a = 1'b1; m_occ_a = 0; ready_cfg = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      o0 = ovf_a;
      for (int k = 0; k < 9; k++) send_byte(8'h16 + 8'(k), 1'b0, 1'b0, -1);
      checks++;
      if (fifo_count_a !== 4'd8) begin
        errors++; $display("FAIL ovf_count r%0d got %0d exp 8", round, fifo_count_a);
      end
      checks++;
      if (ovf_a - o0 != 1) begin
        errors++; $display("FAIL ovf_pulses r%0d got %0d exp 1", round, ovf_a - o0);
      end
      checks++;
      if (evt_a.evt_valid !== 1'b1 || evt_a.evt_code !== 8'h16) begin
        errors++; $display("FAIL ovf_head r%0d got %0h exp 16", round, evt_a.evt_code);
      end
      ready_cfg = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      checks++;
      if (got_a.size() != 8) begin
        errors++; $display("FAIL ovf_drain_count r%0d got %0d exp 8", round, got_a.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          checks++;
          if (got_a[i] !== {2'b00, 8'h16 + 8'(i)}) begin
            errors++; $display("FAIL ovf_drain%0d r%0d got %0h exp %0h", i, round, got_a[i],
                               {2'b00, 8'h16 + 8'(i)});
          end
        end
      end
      checks++;
      if (evt_a.evt_valid !== 1'b0 || fifo_count_a !== 4'd0) begin
        errors++; $display("FAIL ovf_empty r%0d got valid %0b count %0d exp 0 0", round,
                           evt_a.evt_valid, fifo_count_a);
      end
    end
    hold_a = 1'b0; m_occ_a = 0;
  endtask

  task automatic test_timeout();
    int fa0, fb0;
    clear_obs();
    send_byte(8'hE0, 1'b0, 1'b0, -1);
    fa0 = ferr_a; fb0 = ferr_b;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    repeat (TMO - 150) @(posedge clock);
    #1;
    checks++;
    if (ferr_a != fa0) begin
      errors++; $display("FAIL timeout_early got %0d exp 0", ferr_a - fa0);
    end
    repeat (300) @(posedge clock);
    #1;
    checks++;
    if (ferr_a - fa0 != 1 || ferr_b - fb0 != 1) begin
      errors++; $display("FAIL timeout_err got a %0d b %0d exp 1 1", ferr_a - fa0, ferr_b - fb0);
    end
    m_ext_a = 0; m_brk_a = 0; m_ext_b = 0; m_brk_b = 0;
    send_byte(8'h29, 1'b0, 1'b0, -1);
    checks++;
    if (got_a.size() != 1 || (got_a.size() == 1 && got_a[0] !== 10'h029)) begin
      errors++; $display("FAIL timeout_recover got %0d events head %0h exp one 029",
                         got_a.size(), got_a.size() > 0 ? got_a[0] : 10'h3FF);
    end
  endtask

  task automatic test_glitch_reset();
    logic [7:0] code;
    ev_t h;
    clear_obs();
    code = 8'($urandom_range(1, 127));
    send_byte(code, 1'b0, 1'b0, 4);
    checks++;
    if (got_a.size() != 1 || (got_a.size() == 1 && got_a[0] !== {2'b00, code})) begin
      errors++; $display("FAIL glitch_byte got %0d events head %0h exp one %0h",
                         got_a.size(), got_a.size() > 0 ? got_a[0] : 10'h3FF, code);
    end
    hold_a = 1'b1; ready_cfg = 1'b0; m_occ_a = 0;
    repeat (3) @(posedge clock);
    #1;
    send_byte(8'h33, 1'b0, 1'b0, -1);
    checks++;
    if (fifo_count_a !== 4'd1) begin
      errors++; $display("FAIL prereset_count got %0d exp 1", fifo_count_a);
    end
    send_byte(8'hE0, 1'b0, 1'b0, -1);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    h = {evt_a.evt_ext, evt_a.evt_break, evt_a.evt_code};
    checks++;
    if ({evt_a.evt_valid, overflow_a, frame_err_a} !== 3'b000 || fifo_count_a !== 4'd0 ||
        h !== 10'h000) begin
      errors++; $display("FAIL midframe_reset got valid %0b count %0d head %0h exp 0 0 0",
                         evt_a.evt_valid, fifo_count_a, h);
    end
    ps2_dat = 1'b1;
    reset_n = 1'b1;
    clear_obs();
    m_ext_a = 0; m_brk_a = 0; m_ext_b = 0; m_brk_b = 0; m_occ_a = 0;
    hold_a = 1'b0; ready_cfg = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    send_byte(8'h5A, 1'b0, 1'b0, -1);
    checks++;
    if (got_a.size() != 1 || (got_a.size() == 1 && got_a[0] !== 10'h05A)) begin
      errors++; $display("FAIL postreset_event got %0d events head %0h exp one 05a",
                         got_a.size(), got_a.size() > 0 ? got_a[0] : 10'h3FF);
    end
    checks++;
    if (got_b.size() != 1 || (got_b.size() == 1 && got_b[0] !== 10'h05A)) begin
      errors++; $display("FAIL postreset_event_b got %0d events exp one 05a", got_b.size());
    end
  endtask

  initial begin
    evt_b.evt_ready = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_random();
    test_overflow();
    test_timeout();
    test_glitch_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
